// File: rtl/mips_datapath_pkg.sv
// Shared encodings for the multicycle MIPS datapath: ALU functions,
// ALU B-operand selector and next-PC selector.
package mips_datapath_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;

  typedef enum logic [2:0] {
    ALU_AND  = 3'b000,
    ALU_OR   = 3'b001,
    ALU_ADD  = 3'b010,
    ALU_ZERO = 3'b011,
    ALU_ANDN = 3'b100,
    ALU_ORN  = 3'b101,
    ALU_SUB  = 3'b110,
    ALU_SLT  = 3'b111
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    SRCB_REG     = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } srcb_e;

  typedef enum logic [1:0] {
    PCSRC_ALU     = 2'b00,
    PCSRC_ALUOUT  = 2'b01,
    PCSRC_JUMP    = 2'b10,
    PCSRC_ALU_ALT = 2'b11
  } pcsrc_e;

  function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/mips_datapath_alu.sv
// Combinational 32-bit ALU with zero flag and signed-overflow flag.
// Overflow is only meaningful for add/sub; every other function reports 0.
module mips_datapath_alu
  import mips_datapath_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  alu_control,
  output logic [31:0] result,
  output logic        zero,
  output logic        overflow
);

  logic [31:0] sum;
  logic [31:0] diff;

  assign sum  = a + b;
  assign diff = a - b;

  // Function select; SLT compares signed operands directly so it stays
  // correct even when the subtraction would overflow.
  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (alu_control)
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_ADD: begin
        result   = sum;
        overflow = (a[31] == b[31]) && (sum[31] != a[31]);
      end
      ALU_ZERO: result = '0;
      ALU_ANDN: result = a & ~b;
      ALU_ORN:  result = a | ~b;
      ALU_SUB: begin
        result   = diff;
        overflow = (a[31] != b[31]) && (diff[31] != a[31]);
      end
      ALU_SLT:  result = {31'd0, ($signed(a) < $signed(b))};
    endcase
  end

  assign zero = (result == 32'd0);

endmodule

// File: rtl/mips_datapath.sv
// Multicycle MIPS-32 datapath: PC, IR, data register, 32x32 register file,
// ALU and the A/B/ALUOut inter-cycle registers. All sequencing comes from
// the external control FSM through the upper-case control inputs.
module mips_datapath
  import mips_datapath_pkg::*;
(
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        IORD,
  input  logic        REGDST,
  input  logic        MEMTOREG,
  input  logic        IRWRITE,
  input  logic        REGWRITE,
  input  logic        ALUSRCA,
  input  logic        BRANCH,
  input  logic        PCWRITE,
  input  logic [1:0]  ALUSRCB,
  input  logic [1:0]  PCSRC,
  input  logic [2:0]  ALUCONTROL,
  input  logic [31:0] RD,
  output logic [31:0] ADR,
  output logic [31:0] WD,
  output logic        overflow
);

  logic [31:0] pc;
  logic [31:0] data;
  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic [31:0] alu_out;
  // Only the operand fields are held here; opcode/funct decoding belongs
  // to the controller, so IR[31:26] has no consumer inside the datapath.
  logic [25:0] instr;
  logic [31:0] rf [NREG];

  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] sign_imm;
  logic [31:0] jump_target;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic [31:0] pc_next;
  logic        pc_en;

  assign rs          = instr[25:21];
  assign rt          = instr[20:16];
  assign rd          = instr[15:11];
  assign sign_imm    = sign_ext16(instr[15:0]);
  assign jump_target = {pc[31:28], instr[25:0], 2'b00};

  // Register 0 is never written and is cleared by reset, so it always reads 0.
  assign rd1     = rf[rs];
  assign rd2     = rf[rt];
  assign wr_addr = REGDST ? rd : rt;
  assign wr_data = MEMTOREG ? data : alu_out;

  assign src_a = ALUSRCA ? a_reg : pc;

  // ALU B-operand select
  always_comb begin
    src_b = b_reg;
    case (ALUSRCB)
      SRCB_REG:     src_b = b_reg;
      SRCB_FOUR:    src_b = 32'd4;
      SRCB_IMM:     src_b = sign_imm;
      SRCB_IMM_SH2: src_b = {sign_imm[29:0], 2'b00};
    endcase
  end

  mips_datapath_alu u_alu (
    .a           (src_a),
    .b           (src_b),
    .alu_control (ALUCONTROL),
    .result      (alu_result),
    .zero        (alu_zero),
    .overflow    (overflow)
  );

  // Next-PC select
  always_comb begin
    pc_next = alu_result;
    case (PCSRC)
      PCSRC_ALU:     pc_next = alu_result;
      PCSRC_ALUOUT:  pc_next = alu_out;
      PCSRC_JUMP:    pc_next = jump_target;
      PCSRC_ALU_ALT: pc_next = alu_result;
    endcase
  end

  assign pc_en = PCWRITE | (BRANCH & alu_zero);

  // PC, IR and the per-cycle pipeline registers
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      pc      <= '0;
      instr   <= '0;
      data    <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      alu_out <= '0;
    end else begin
      if (pc_en)   pc    <= pc_next;
      if (IRWRITE) instr <= RD[25:0];
      data    <= RD;
      a_reg   <= rd1;
      b_reg   <= rd2;
      alu_out <= alu_result;
    end
  end

  // Register file write port; writes to register 0 are dropped
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (REGWRITE && (wr_addr != 5'd0)) begin
      rf[wr_addr] <= wr_data;
    end
  end

  assign ADR = IORD ? alu_out : pc;
  assign WD  = b_reg;

endmodule

// File: tb/tb_mips_datapath.sv
// Directed-vector bench for mips_datapath. Inputs change 1 time unit after
// the rising edge; outputs are sampled before the following edge.
module tb_mips_datapath;

  logic        CLOCK;
  logic        RESET;
  logic        IORD;
  logic        REGDST;
  logic        MEMTOREG;
  logic        IRWRITE;
  logic        REGWRITE;
  logic        ALUSRCA;
  logic        BRANCH;
  logic        PCWRITE;
  logic [1:0]  ALUSRCB;
  logic [1:0]  PCSRC;
  logic [2:0]  ALUCONTROL;
  logic [31:0] RD;
  logic [31:0] ADR;
  logic [31:0] WD;
  logic        overflow;

  int n_vec = 0;
  int n_err = 0;

  mips_datapath dut (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .IORD       (IORD),
    .REGDST     (REGDST),
    .MEMTOREG   (MEMTOREG),
    .IRWRITE    (IRWRITE),
    .REGWRITE   (REGWRITE),
    .ALUSRCA    (ALUSRCA),
    .BRANCH     (BRANCH),
    .PCWRITE    (PCWRITE),
    .ALUSRCB    (ALUSRCB),
    .PCSRC      (PCSRC),
    .ALUCONTROL (ALUCONTROL),
    .RD         (RD),
    .ADR        (ADR),
    .WD         (WD),
    .overflow   (overflow)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic idle();
    IORD = 0; REGDST = 0; MEMTOREG = 0; IRWRITE = 0; REGWRITE = 0;
    ALUSRCA = 0; BRANCH = 0; PCWRITE = 0; ALUSRCB = 2'b00; PCSRC = 2'b00;
    ALUCONTROL = 3'b000;
  endtask

  // IR <- instr (rt names target), Data <- value, then rt <- Data
  task automatic load_reg(input logic [31:0] instr, input logic [31:0] value);
    idle(); IRWRITE = 1; RD = instr; tick();
    idle(); RD = value; tick();
    MEMTOREG = 1; REGDST = 0; REGWRITE = 1; tick();
    idle();
  endtask

  // A op B: overflow checked before the edge, result read back via ALUOut
  task automatic alu_op(input logic [2:0] op, input logic [31:0] exp_res,
                        input logic exp_ovf, input string tag);
    ALUSRCA = 1; ALUSRCB = 2'b00; ALUCONTROL = op; IORD = 1;
    #1;
    check_vec({tag, "_ovf"}, {31'd0, overflow}, {31'd0, exp_ovf});
    tick();
    check_vec({tag, "_res"}, ADR, exp_res);
  endtask

  initial begin
    RESET = 0; RD = '0; idle();
    #1;
    check_vec("por_adr", ADR, 32'h0);
    check_vec("por_wd", WD, 32'h0);
    #2 RESET = 1;
    tick();

    // fetch: IR <- RD, PC <- PC + 4
    IORD = 0; IRWRITE = 1; ALUSRCA = 0; ALUSRCB = 2'b01; ALUCONTROL = 3'b010;
    PCSRC = 2'b00; PCWRITE = 1; RD = 32'h8C010004;
    #1 check_vec("fetch_adr_pre", ADR, 32'h0);
    tick(); idle(); #1;
    check_vec("fetch_pc", ADR, 32'h4);
    IORD = 1; #1;
    check_vec("fetch_aluout", ADR, 32'h4);

    // load: address = $0 + 4, Data <- RD, $1 <- Data
    idle(); ALUSRCA = 1; ALUSRCB = 2'b10; ALUCONTROL = 3'b010;
    tick(); idle(); IORD = 1; RD = 32'h12345678; #1;
    check_vec("ld_adr", ADR, 32'h4);
    tick(); idle(); MEMTOREG = 1; REGDST = 0; REGWRITE = 1;
    tick(); idle(); #1;
    check_vec("wr_same_edge_b", WD, 32'h0);
    tick();
    check_vec("ld_wd", WD, 32'h12345678);

    // $2 <- 5 through ALUOut
    IRWRITE = 1; RD = 32'h20020005; tick();
    idle(); ALUSRCA = 1; ALUSRCB = 2'b10; ALUCONTROL = 3'b010; tick();
    idle(); REGWRITE = 1; MEMTOREG = 0; REGDST = 0; tick();

    // beq $2,$2 : taken
    idle(); IRWRITE = 1; RD = 32'h10420003; tick();
    idle(); ALUSRCA = 0; ALUSRCB = 2'b11; ALUCONTROL = 3'b010; tick();
    idle(); #1;
    check_vec("br_wd", WD, 32'h5);
    IORD = 1; #1;
    check_vec("br_target", ADR, 32'h10);
    idle(); ALUSRCA = 1; ALUSRCB = 2'b00; ALUCONTROL = 3'b110; BRANCH = 1; PCSRC = 2'b01;
    tick(); idle(); #1;
    check_vec("br_taken", ADR, 32'h10);

    // beq $2,$1 : not taken
    IRWRITE = 1; RD = 32'h10410003; tick();
    idle(); ALUSRCA = 0; ALUSRCB = 2'b11; ALUCONTROL = 3'b010; tick();
    idle(); ALUSRCA = 1; ALUSRCB = 2'b00; ALUCONTROL = 3'b110; BRANCH = 1; PCSRC = 2'b01;
    #1 check_vec("br_sub_ovf", {31'd0, overflow}, 32'h0);
    tick(); idle(); #1;
    check_vec("br_not_taken", ADR, 32'h10);

    // overflow cases
    load_reg(32'h8C030000, 32'h7FFFFFFF);
    load_reg(32'h8C040000, 32'h00000001);
    load_reg(32'h8C060000, 32'h80000000);
    IRWRITE = 1; RD = 32'h00642820; tick();
    idle(); tick();
    check_vec("add_wd", WD, 32'h1);
    alu_op(3'b010, 32'h80000000, 1'b1, "add_max");
    alu_op(3'b000, 32'h00000001, 1'b0, "and_max");
    alu_op(3'b110, 32'h7FFFFFFE, 1'b0, "sub_max");

    idle(); IRWRITE = 1; RD = 32'h00C42022; tick();
    idle(); tick();
    alu_op(3'b110, 32'h7FFFFFFF, 1'b1, "sub_min");
    alu_op(3'b111, 32'h00000001, 1'b0, "slt_min");
    alu_op(3'b100, 32'h80000000, 1'b0, "andn_min");
    alu_op(3'b101, 32'hFFFFFFFE, 1'b0, "orn_min");
    alu_op(3'b001, 32'h80000001, 1'b0, "or_min");
    alu_op(3'b011, 32'h00000000, 1'b0, "zero_min");
    alu_op(3'b010, 32'h80000001, 1'b0, "add_min");

    // writes to $0 are dropped
    load_reg(32'h8C000000, 32'hFFFFFFFF);
    tick(); tick();
    check_vec("r0_wd", WD, 32'h0);

    // jump, with IR reloaded on the same edge
    idle(); IRWRITE = 1; RD = 32'h08000010; tick();
    idle(); PCWRITE = 1; PCSRC = 2'b10; IRWRITE = 1; RD = 32'h08000020; tick();
    idle(); #1;
    check_vec("jmp_pc", ADR, 32'h40);
    PCWRITE = 1; PCSRC = 2'b10; tick();
    idle(); #1;
    check_vec("jmp2_pc", ADR, 32'h80);

    // PCWRITE with BRANCH and zero clear still writes PC
    ALUSRCA = 0; ALUSRCB = 2'b01; ALUCONTROL = 3'b010; PCSRC = 2'b00; BRANCH = 1; PCWRITE = 1;
    tick(); idle(); #1;
    check_vec("pcw_br_pc", ADR, 32'h84);
    ALUSRCA = 0; ALUSRCB = 2'b01; ALUCONTROL = 3'b010; PCSRC = 2'b11; PCWRITE = 1;
    tick(); idle(); #1;
    check_vec("pcsrc11_pc", ADR, 32'h88);

    // asynchronous reset mid-cycle
    IRWRITE = 1; RD = 32'h8C010004; tick();
    idle(); tick();
    check_vec("pre_rst_wd", WD, 32'h12345678);
    #2 RESET = 0;
    #1;
    check_vec("rst_adr", ADR, 32'h0);
    check_vec("rst_wd", WD, 32'h0);
    IORD = 1; #1;
    check_vec("rst_aluout", ADR, 32'h0);
    RESET = 1; idle();
    tick();
    IRWRITE = 1; RD = 32'h8C010004; tick();
    idle(); tick();
    check_vec("rst_rf_clear", WD, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mips_datapath.md
# mips_datapath

Multicycle MIPS-32 datapath: program counter, instruction and data registers, 32×32 register file, ALU and the inter-cycle pipeline registers (A, B, ALUOut). It sits between the multicycle control FSM, which drives all control inputs, and a unified instruction/data memory, which receives ADR/WD and returns RD. The block contains no control decoding; every cycle's behaviour is fully determined by the control inputs.

## Interface
- No parameters; data width fixed at 32, register count fixed at 32.
- CLOCK  in  1  system clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- IORD  in  1  memory address select: 0 = PC, 1 = ALUOut.
- REGDST  in  1  register write address: 0 = instr[20:16] (rt), 1 = instr[15:11] (rd).
- MEMTOREG  in  1  register write data: 0 = ALUOut, 1 = Data register.
- IRWRITE  in  1  load instruction register from RD.
- REGWRITE  in  1  register file write enable.
- ALUSRCA  in  1  ALU A operand: 0 = PC, 1 = A register.
- BRANCH  in  1  conditional PC write when ALU zero flag set.
- PCWRITE  in  1  unconditional PC write.
- ALUSRCB  in  2  ALU B operand: 00 = B register, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2.
- PCSRC  in  2  next PC: 00 = ALUResult, 01 = ALUOut, 10 = jump target, 11 = ALUResult.
- ALUCONTROL  in  3  ALU function (below).
- RD  in  32  memory read data.
- ADR  out  32  memory address.
- WD  out  32  memory write data (B register).
- overflow  out  1  signed overflow of current ALU operation.

## Operation
- SignImm = sign-extend instr[15:0]; jump target = {PC[31:28], instr[25:0], 2'b00}.
- ALU (combinational): 010 add, 110 sub, 000 AND, 001 OR, 111 SLT (signed A<B → 1, else 0), 100 A AND ~B, 101 A OR ~B, 011 result 0.
- zero = (ALUResult == 0).
- overflow: add → operands same sign and result sign differs; sub → operands differ in sign and result sign differs from A; all other functions → 0. Combinational, never latched.
- PC enable = PCWRITE | (BRANCH & zero).
- Register file: two combinational read ports addressed by instr[25:21] and instr[20:16]; one write port. Register 0 reads 0 always; writes to it are discarded.
- ADR = IORD ? ALUOut : PC (combinational mux). WD = B register.
- Arithmetic modulo 2^32; no traps on overflow.

## Timing
- Rising edge of CLOCK, when RESET high:
  - PC ← next PC if PC enable.
  - IR ← RD if IRWRITE.
  - Data ← RD every cycle.
  - A, B ← register file read ports every cycle.
  - ALUOut ← ALUResult every cycle.
  - Register file write if REGWRITE.
- RESET low (asynchronous, any time): PC, IR, Data, A, B, ALUOut and all 32 registers cleared to 0 immediately. Outputs during/after reset: ADR = 0, WD = 0; overflow follows the combinational ALU path. Control inputs are ignored while RESET is low.
- Register write in cycle N is visible on read ports combinationally after edge N and in A/B after edge N+1. A same-cycle read of the written register returns the old value.
- IR written and PC updated on the same edge: both use pre-edge values (jump target uses old IR/PC).
- PCWRITE and BRANCH both set: PC written regardless of zero.

## Structure
- Shared package: ALUCONTROL encodings, ALUSRCB and PCSRC selector encodings as enumerated constants.
- One sub-module: alu (operands, ALUCONTROL → result, zero, overflow). Register file inline, or as a second optional sub-module regfile.
- Remaining muxes and registers in the top level.

## Test plan
- Reset: drive RESET low mid-cycle → ADR = 0 and WD = 0 immediately, with no clock edge needed.
- Fetch: IORD=0, IRWRITE=1, ALUSRCA=0, ALUSRCB=01, ALUCONTROL=010, PCSRC=00, PCWRITE=1, RD=0x8C010004 → IR loaded; next cycle ADR = 4.
- Load path: register $0 base, ALUSRCA=1, ALUSRCB=10, add → ALUOut = 4; IORD=1 gives ADR = 4. RD=0x12345678 with MEMTOREG=1, REGDST=0, REGWRITE=1 writes $1. A later instruction reading $1 as rt gives WD = 0x12345678.
- Branch: A = B (both 5), ALUCONTROL=110, BRANCH=1, PCSRC=01 → PC loaded from ALUOut. With A ≠ B, PC is unchanged.
- Overflow: A = 0x7FFFFFFF, B = 1, add → overflow = 1, ALUResult = 0x80000000. Sub of 0x80000000 − 1 → overflow = 1. AND → overflow = 0.
- Register 0: write 0xFFFFFFFF to $0 → subsequent read of $0 gives WD = 0. Jump: PCSRC=10, IR = 0x08000010 → PC = 0x00000040.
